// File: rtl/tri_color_pwm_pkg.sv
// Shared constants and the 32-to-8 bit duty saturation used by the tri-colour PWM block.
package tri_color_pwm_pkg;

  localparam int DUTY_W   = 8;
  localparam int DUTY_MAX = 255;
  localparam int PERIOD   = 255;

  // Anything that does not fit in a duty byte is clamped to fully on.
  function automatic logic [DUTY_W-1:0] sat8(input logic [31:0] value);
    if (value > 32'(DUTY_MAX)) begin
      return DUTY_W'(DUTY_MAX);
    end
    return value[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: stb/ack acceptor, pending/active duty registers and output comparator.
module pwm_channel
  import tri_color_pwm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  stb_i,
  output logic                  ack_o,
  input  logic                  wrap_i,
  input  logic [DUTY_W-1:0]     count_i,
  output logic                  led_o
);

  logic              ack_q, ack_d;
  logic [DUTY_W-1:0] pending_q, pending_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              led_q, led_d;
  logic              xfer;
  logic [31:0]       data32;

  assign data32 = 32'(data_i);
  assign xfer   = stb_i & ack_q;

  // Ack drops for one cycle after each transfer; the wrap copies the pending value as it stood before this edge.
  always_comb begin
    ack_d     = ~xfer;
    pending_d = pending_q;
    active_d  = active_q;
    led_d     = (count_i < active_q);
    if (xfer) begin
      pending_d = sat8(data32);
    end
    if (wrap_i) begin
      active_d = pending_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q     <= 1'b0;
      pending_q <= '0;
      active_q  <= '0;
      led_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      led_q     <= led_d;
    end
  end

  assign ack_o = ack_q;
  assign led_o = led_q;

endmodule

// File: rtl/tri_color_pwm.sv
// Tri-colour PWM driver: shared prescaler and period counter feeding three duty-stream channels.
module tri_color_pwm
  import tri_color_pwm_pkg::*;
#(
  parameter int PRESCALE   = 4,
  parameter int PERIOD     = tri_color_pwm_pkg::PERIOD,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_led_r,
  input  logic                  input_led_r_stb,
  output logic                  input_led_r_ack,
  input  logic [DATA_WIDTH-1:0] input_led_g,
  input  logic                  input_led_g_stb,
  output logic                  input_led_g_ack,
  input  logic [DATA_WIDTH-1:0] input_led_b,
  input  logic                  input_led_b_stb,
  output logic                  input_led_b_ack,
  output logic                  led_r,
  output logic                  led_g,
  output logic                  led_b,
  output logic                  period_start
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   prescale_q, prescale_d;
  logic [DUTY_W-1:0] count_q, count_d;
  logic              period_start_q;
  logic              step;
  logic              wrap;

  assign step = (prescale_q == PS_W'(PRESCALE - 1));
  assign wrap = step && (count_q == DUTY_W'(PERIOD - 1));

  always_comb begin
    prescale_d = prescale_q + 1'b1;
    count_d    = count_q;
    if (step) begin
      prescale_d = '0;
      count_d    = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q     <= '0;
      count_q        <= '0;
      period_start_q <= 1'b0;
    end else begin
      prescale_q     <= prescale_d;
      count_q        <= count_d;
      period_start_q <= wrap;
    end
  end

  assign period_start = period_start_q;

  pwm_channel #(.DATA_WIDTH(DATA_WIDTH)) u_red (
    .clk     (clk),
    .rst     (rst),
    .data_i  (input_led_r),
    .stb_i   (input_led_r_stb),
    .ack_o   (input_led_r_ack),
    .wrap_i  (wrap),
    .count_i (count_q),
    .led_o   (led_r)
  );

  pwm_channel #(.DATA_WIDTH(DATA_WIDTH)) u_green (
    .clk     (clk),
    .rst     (rst),
    .data_i  (input_led_g),
    .stb_i   (input_led_g_stb),
    .ack_o   (input_led_g_ack),
    .wrap_i  (wrap),
    .count_i (count_q),
    .led_o   (led_g)
  );

  pwm_channel #(.DATA_WIDTH(DATA_WIDTH)) u_blue (
    .clk     (clk),
    .rst     (rst),
    .data_i  (input_led_b),
    .stb_i   (input_led_b_stb),
    .ack_o   (input_led_b_ack),
    .wrap_i  (wrap),
    .count_i (count_q),
    .led_o   (led_b)
  );

endmodule
